// File: rtl/mc_boot_seq.sv
`default_nettype none
// ============================================================================
// Module      : mc_boot_seq
// Description : Open-loop BLDC start-up sequencer. Walks the boot command RAM,
//               applying each entry's phase/PWM for delay x prediv HCLK
//               cycles, and pulses done at the end-of-table sentinel or when
//               the last RAM entry has been applied.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_boot_seq #(
  parameter int ADDR_W  = 10,
  parameter int DELAY_W = 14,
  parameter int PWM_W   = 12
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [11:0]                prediv_i,
  output logic [ADDR_W-1:0]          cmd_addr_o,
  input  logic [DELAY_W+3+PWM_W-1:0] cmd_data_i,
  output logic [2:0]                 phase_o,
  output logic [PWM_W-1:0]           pwm_o,
  output logic                       drive_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       aborted_o,
  output logic [ADDR_W-1:0]          step_idx_o
);

  localparam int c_DATA_W = DELAY_W + 3 + PWM_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    step_idx_q;
  logic [2:0]           phase_q;
  logic [PWM_W-1:0]     pwm_q;
  logic                 drive_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 aborted_q;
  logic [DELAY_W-1:0]   dcnt_q;
  logic [11:0]          presc_q;
  logic [11:0]          div_q;

  // Field decode of the BRAM word: {delay, phase, pwm}
  logic [DELAY_W-1:0]   w_delay;
  logic [2:0]           w_phase;
  logic [PWM_W-1:0]     w_pwm;
  logic [11:0]          w_div;
  logic                 w_tick;
  logic                 w_last_addr;
  logic                 w_last_tick;

  assign w_delay     = cmd_data_i[c_DATA_W-1 -: DELAY_W];
  assign w_phase     = cmd_data_i[PWM_W+2:PWM_W];
  assign w_pwm       = cmd_data_i[PWM_W-1:0];
  // A divider of zero behaves as one so the prescaler always ticks
  assign w_div       = (prediv_i == 12'd0) ? 12'd1 : prediv_i;
  // div_q holds the divider captured at the last wrap, so a live change of
  // prediv only alters the period from the next wrap onwards
  assign w_tick      = (presc_q == (div_q - 12'd1));
  assign w_last_addr = &addr_q;
  assign w_last_tick = w_tick && (dcnt_q == DELAY_W'(1));

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      step_idx_q <= '0;
      phase_q    <= '0;
      pwm_q      <= '0;
      drive_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      dcnt_q     <= '0;
      presc_q    <= '0;
      div_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_i && (state_q == S_FETCH || state_q == S_LATCH || state_q == S_RUN)) begin
        // Abort drops the motor drive at once and clears the duty
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        drive_en_q <= 1'b0;
        aborted_q  <= 1'b1;
        phase_q    <= '0;
        pwm_q      <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              addr_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            // BRAM read latency of one cycle
            state_q <= S_LATCH;
          end
          S_LATCH: begin
            if (w_delay == '0) begin
              // End-of-table sentinel; last phase/pwm stay on the outputs
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              drive_en_q <= 1'b0;
            end else begin
              phase_q    <= w_phase;
              pwm_q      <= w_pwm;
              step_idx_q <= addr_q;
              dcnt_q     <= w_delay;
              presc_q    <= '0;
              div_q      <= w_div;
              drive_en_q <= 1'b1;
              state_q    <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_tick) begin
              presc_q <= '0;
              div_q   <= w_div;
              dcnt_q  <= dcnt_q - DELAY_W'(1);
            end else begin
              presc_q <= presc_q + 12'd1;
            end
            if (w_last_tick) begin
              if (w_last_addr) begin
                // Table exhausted: no address wrap, finish here
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                drive_en_q <= 1'b0;
              end else begin
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            drive_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_addr_o = addr_q;
  assign phase_o    = phase_q;
  assign pwm_o      = pwm_q;
  assign drive_en_o = drive_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;
  assign step_idx_o = step_idx_q;

endmodule
`default_nettype wire
